// File: rtl/gmii_frame_tx_if.sv
// Byte-wide AXI-Stream link carrying frame payload into the GMII transmitter.
interface gmii_frame_tx_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/gmii_frame_tx.sv
// GMII frame transmitter: wraps an AXI-Stream payload with preamble/SFD,
// optional zero padding and a CRC-32 FCS, then enforces the inter-frame gap.
module gmii_frame_tx #(
  parameter int ENABLE_PADDING   = 1,
  parameter int MIN_FRAME_LENGTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  gmii_frame_tx_if.slave    s_axis,
  output logic [7:0]        gmii_txd,
  output logic              gmii_tx_en,
  output logic              gmii_tx_er,
  input  logic [7:0]        cfg_ifg,
  input  logic              cfg_tx_enable,
  output logic              start_packet,
  output logic              error_underflow
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, PAYLOAD, PAD, FCS, WAIT_END, IFG
  } state_t;

  // Payload + pad bytes that must precede the 4-byte FCS.
  localparam logic [15:0] PAD_LEN = 16'(MIN_FRAME_LENGTH - 4);
  localparam logic [7:0]  MIN_IFG = 8'd12;

  state_t      state;
  logic        tready_r;
  logic [2:0]  pre_cnt;
  logic [15:0] byte_cnt;
  logic [1:0]  fcs_idx;
  logic [7:0]  ifg_cnt;
  logic [31:0] crc;
  logic [31:0] fcs_word;
  logic [7:0]  gap;
  logic        pad_needed;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign s_axis.tready = tready_r;
  assign fcs_word      = ~crc;

  // Effective gap length and pad decision for the byte being accepted now.
  always_comb begin
    gap        = (cfg_ifg < MIN_IFG) ? MIN_IFG : cfg_ifg;
    pad_needed = (ENABLE_PADDING != 0) && (sat_inc(byte_cnt) < PAD_LEN);
  end

  // Frame sequencer; every output is a register describing the next byte time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      gmii_txd        <= 8'h00;
      gmii_tx_en      <= 1'b0;
      gmii_tx_er      <= 1'b0;
      tready_r        <= 1'b0;
      start_packet    <= 1'b0;
      error_underflow <= 1'b0;
      pre_cnt         <= 3'd0;
      byte_cnt        <= 16'd0;
      fcs_idx         <= 2'd0;
      ifg_cnt         <= 8'd0;
      crc             <= 32'hFFFFFFFF;
    end else begin
      start_packet    <= 1'b0;
      error_underflow <= 1'b0;
      case (state)
        IDLE: begin
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b0;
          gmii_tx_er <= 1'b0;
          tready_r   <= 1'b0;
          if (s_axis.tvalid && cfg_tx_enable) begin
            state      <= PREAMBLE;
            gmii_txd   <= 8'h55;
            gmii_tx_en <= 1'b1;
            pre_cnt    <= 3'd1;
            byte_cnt   <= 16'd0;
            crc        <= 32'hFFFFFFFF;
          end
        end
        PREAMBLE: begin
          if (pre_cnt == 3'd7) begin
            gmii_txd     <= 8'hD5;
            tready_r     <= 1'b1;
            start_packet <= 1'b1;
            state        <= PAYLOAD;
          end else begin
            gmii_txd <= 8'h55;
            pre_cnt  <= pre_cnt + 3'd1;
          end
        end
        PAYLOAD: begin
          // tready is high throughout this state, so tvalid alone means a beat.
          if (s_axis.tvalid) begin
            gmii_txd   <= s_axis.tdata;
            gmii_tx_en <= 1'b1;
            byte_cnt   <= sat_inc(byte_cnt);
            crc        <= crc32_byte(crc, s_axis.tdata);
            if (s_axis.tlast) begin
              tready_r <= 1'b0;
              if (s_axis.tuser) begin
                gmii_tx_er <= 1'b1;
                ifg_cnt    <= 8'd0;
                state      <= IFG;
              end else if (pad_needed) begin
                state <= PAD;
              end else begin
                fcs_idx <= 2'd0;
                state   <= FCS;
              end
            end
          end else begin
            // Source starved mid-frame: poison the frame and drain the rest.
            gmii_txd        <= 8'h00;
            gmii_tx_en      <= 1'b1;
            gmii_tx_er      <= 1'b1;
            error_underflow <= 1'b1;
            state           <= WAIT_END;
          end
        end
        PAD: begin
          gmii_txd <= 8'h00;
          byte_cnt <= sat_inc(byte_cnt);
          crc      <= crc32_byte(crc, 8'h00);
          if (sat_inc(byte_cnt) >= PAD_LEN) begin
            fcs_idx <= 2'd0;
            state   <= FCS;
          end
        end
        FCS: begin
          gmii_txd <= fcs_word[8*fcs_idx +: 8];
          fcs_idx  <= fcs_idx + 2'd1;
          if (fcs_idx == 2'd3) begin
            ifg_cnt <= 8'd0;
            state   <= IFG;
          end
        end
        WAIT_END: begin
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b0;
          gmii_tx_er <= 1'b0;
          if (s_axis.tvalid && s_axis.tlast) begin
            tready_r <= 1'b0;
            ifg_cnt  <= 8'd0;
            state    <= IFG;
          end
        end
        IFG: begin
          // ifg_cnt counts idle byte times already scheduled; the final one
          // is spent in IDLE, where the next start decision is made.
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b0;
          gmii_tx_er <= 1'b0;
          tready_r   <= 1'b0;
          if (({1'b0, ifg_cnt} + 9'd1) >= {1'b0, gap}) begin
            state <= IDLE;
          end else begin
            ifg_cnt <= ifg_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_frame_tx.sv
// Bench for gmii_frame_tx: a padding DUT and a non-padding DUT share one stimulus.
module tb_gmii_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] cfg_ifg = 8'd12;
  logic       cfg_tx_enable = 1'b1;
  logic [7:0] tdata = 8'h00;
  logic       tvalid = 1'b0;
  logic       tlast = 1'b0;
  logic       tuser = 1'b0;

  logic [7:0] a_txd, b_txd;
  logic       a_en, a_er, a_sp, a_uf;
  logic       b_en, b_er, b_sp, b_uf;

  gmii_frame_tx_if sif_a();
  gmii_frame_tx_if sif_b();

  assign sif_a.tdata  = tdata;
  assign sif_a.tvalid = tvalid;
  assign sif_a.tlast  = tlast;
  assign sif_a.tuser  = tuser;
  assign sif_b.tdata  = tdata;
  assign sif_b.tvalid = tvalid;
  assign sif_b.tlast  = tlast;
  assign sif_b.tuser  = tuser;

  always #5 clk = ~clk;

  gmii_frame_tx dut_a (
    .clk(clk), .rst(rst), .s_axis(sif_a),
    .gmii_txd(a_txd), .gmii_tx_en(a_en), .gmii_tx_er(a_er),
    .cfg_ifg(cfg_ifg), .cfg_tx_enable(cfg_tx_enable),
    .start_packet(a_sp), .error_underflow(a_uf)
  );

  gmii_frame_tx #(.ENABLE_PADDING(0), .MIN_FRAME_LENGTH(64)) dut_b (
    .clk(clk), .rst(rst), .s_axis(sif_b),
    .gmii_txd(b_txd), .gmii_tx_en(b_en), .gmii_tx_er(b_er),
    .cfg_ifg(cfg_ifg), .cfg_tx_enable(cfg_tx_enable),
    .start_packet(b_sp), .error_underflow(b_uf)
  );

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    int len; int drop; int abort;
    int len_a; int len_b;
    int er; int er_pos; int er_data; int uf; int fcs;
  } vec_t;
  vec_t vecs[8];

  // Monitor state
  logic [7:0] capA[$];
  logic [7:0] capB[$];
  bit         rdyA[$];
  int         gapA[$];
  int framesA = 0, framesB = 0;
  int erA = 0, erposA = -1, erdA = 0;
  int spA = -1, spcntA = 0;
  int ufcntA = 0, ufposA = -1;
  int lowA = 0, enCntA = 0;
  bit prevA = 0, prevB = 0;
  int f0a, f0b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Capture both GMII streams away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        capA.delete(); capB.delete(); rdyA.delete();
        erA = 0; erposA = -1; spA = -1; spcntA = 0; ufcntA = 0; ufposA = -1;
        prevA = 0; prevB = 0; lowA = 0;
      end else begin
        if (a_en) begin
          if (!prevA) begin
            capA.delete(); rdyA.delete();
            erA = 0; erposA = -1; spA = -1; spcntA = 0; ufcntA = 0; ufposA = -1;
            gapA.push_back(lowA);
          end
          capA.push_back(a_txd);
          rdyA.push_back(sif_a.tready);
          enCntA++;
          if (a_er) begin erA++; erposA = capA.size() - 1; erdA = int'(a_txd); end
          if (a_sp) begin spA = capA.size() - 1; spcntA++; end
          if (a_uf) begin ufcntA++; ufposA = capA.size() - 1; end
          lowA = 0;
        end else begin
          lowA++;
          if (a_uf) ufcntA++;
        end
        if (prevA && !a_en) framesA++;
        prevA = a_en;
        if (b_en) begin
          if (!prevB) capB.delete();
          capB.push_back(b_txd);
        end
        if (prevB && !b_en) framesB++;
        prevB = b_en;
      end
    end
  end

  task automatic drive_beat(input int i, input int len, input int abort);
    tvalid = 1'b1;
    tdata  = 8'(8'h31 + i);
    tlast  = (i == len - 1);
    tuser  = (abort != 0) && (i == len - 1);
  endtask

  // Feed one frame; called at posedge+1. Optional one-cycle tvalid gap after
  // drop_after beats, or an asynchronous reset after rst_after beats.
  task automatic send_frame(input int len, input int drop_after, input int abort, input int rst_after);
    int i;
    int guard;
    bit acc;
    i = 0;
    guard = 0;
    drive_beat(0, len, abort);
    while (i < len && guard < 3000) begin
      @(negedge clk);
      acc = tvalid && sif_a.tready;
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        i++;
        if (i == rst_after) begin
          tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
          chk("pre_reset_tx_en", 32'(a_en), 1);
          rst = 1'b1;
          #1;
          chk("reset_mid_tx_en", 32'(a_en), 0);
          chk("reset_mid_txd", 32'(a_txd), 0);
          chk("reset_mid_tready", 32'(sif_a.tready), 0);
          return;
        end
        if (i == drop_after) begin
          tvalid = 1'b0;
          @(posedge clk); #1;
        end
        if (i < len) drive_beat(i, len, abort);
        else begin tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; end
      end
    end
    chk("send_complete", i, len);
  endtask

  task automatic check_frame(input vec_t v);
    int bad;
    int nd;
    logic [31:0] r;
    chk("len_a", capA.size(), v.len_a);
    chk("len_b", capB.size(), v.len_b);
    chk("frames_a", framesA - f0a, 1);
    chk("frames_b", framesB - f0b, 1);
    bad = 0;
    if (capA.size() < 8) bad = 1;
    else begin
      for (int k = 0; k < 7; k++) if (capA[k] != 8'h55) bad++;
      if (capA[7] != 8'hD5) bad++;
    end
    chk("preamble_sfd", bad, 0);
    chk("sfd_pulse_pos", spA, 7);
    chk("sfd_pulse_cnt", spcntA, 1);
    nd = (v.drop >= 0) ? v.drop : v.len;
    bad = 0;
    for (int k = 0; k < nd; k++) begin
      if (8 + k >= capA.size() || capA[8 + k] != 8'(8'h31 + k)) bad++;
      if (8 + k >= capB.size() || capB[8 + k] != 8'(8'h31 + k)) bad++;
    end
    chk("payload_bytes", bad, 0);
    chk("tx_er_count", erA, v.er);
    if (v.er != 0) begin
      chk("tx_er_pos", erposA, v.er_pos);
      chk("tx_er_data", erdA, v.er_data);
    end
    chk("underflow_pulses", ufcntA, v.uf);
    if (v.uf != 0) chk("underflow_pos", ufposA, v.er_pos);
    if (v.fcs != 0) begin
      r = 32'hFFFFFFFF;
      for (int k = 8; k < capA.size(); k++) r = crc_step(r, capA[k]);
      chk("fcs_residue_a", r, 32'hDEBB20E3);
      r = 32'hFFFFFFFF;
      for (int k = 8; k < capB.size(); k++) r = crc_step(r, capB[k]);
      chk("fcs_residue_b", r, 32'hDEBB20E3);
      if (v.len < 60) begin
        bad = 0;
        for (int k = 8 + v.len; k < v.len_a - 4; k++) begin
          if (k >= capA.size() || capA[k] != 8'h00 || rdyA[k] != 1'b0) bad++;
        end
        chk("pad_zero_tready_low", bad, 0);
      end
      if (v.len == 9) begin
        if (capB.size() >= 21) chk("kat_fcs_123456789", {capB[20], capB[19], capB[18], capB[17]}, 32'hCBF43926);
        else chk("kat_fcs_len", capB.size(), 21);
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    f0a = framesA;
    f0b = framesB;
    send_frame(v.len, v.drop, v.abort, -1);
    repeat (150) @(posedge clk);
    #1;
    check_frame(v);
  endtask

  initial begin
    int exp_gap[3];
    logic [7:0] ifg_set[3];
    int en0;

    vecs[0] = '{9,   -1, 0, 72, 21, 0, 0,  0,     0, 1};
    vecs[1] = '{10,  -1, 0, 72, 22, 0, 0,  0,     0, 1};
    vecs[2] = '{1,   -1, 0, 72, 13, 0, 0,  0,     0, 1};
    vecs[3] = '{59,  -1, 0, 72, 71, 0, 0,  0,     0, 1};
    vecs[4] = '{60,  -1, 0, 72, 72, 0, 0,  0,     0, 1};
    vecs[5] = '{64,  -1, 0, 76, 76, 0, 0,  0,     0, 1};
    vecs[6] = '{100, 20, 0, 29, 29, 1, 28, 0,     1, 0};
    vecs[7] = '{64,  -1, 1, 72, 72, 1, 71, 'h70,  0, 0};
    ifg_set[0] = 8'd12; exp_gap[0] = 12;
    ifg_set[1] = 8'd5;  exp_gap[1] = 12;
    ifg_set[2] = 8'd20; exp_gap[2] = 20;

    #2 rst = 1'b1;
    #1;
    chk("reset_tx_en", 32'(a_en), 0);
    chk("reset_txd", 32'(a_txd), 0);
    chk("reset_er_tready_pulses", {28'h0, a_er, sif_a.tready, a_sp, a_uf}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 8; n++) run_vec(vecs[n]);

    // New frames are held off while transmit is disabled.
    en0 = enCntA;
    cfg_tx_enable = 1'b0;
    drive_beat(0, 64, 0);
    repeat (30) @(posedge clk);
    #1;
    chk("disabled_no_tx", enCntA - en0, 0);
    chk("disabled_tready", 32'(sif_a.tready), 0);

    // Enable then drop it mid-frame; the frame in flight must complete.
    cfg_tx_enable = 1'b1;
    f0a = framesA;
    f0b = framesB;
    fork
      send_frame(64, -1, 0, -1);
      begin
        repeat (25) @(posedge clk);
        #2 cfg_tx_enable = 1'b0;
      end
    join
    repeat (150) @(posedge clk);
    #1;
    check_frame(vecs[5]);
    cfg_tx_enable = 1'b1;

    // Back-to-back frames: gap is max(cfg_ifg, 12).
    for (int g = 0; g < 3; g++) begin
      cfg_ifg = ifg_set[g];
      gapA.delete();
      f0a = framesA;
      send_frame(64, -1, 0, -1);
      send_frame(64, -1, 0, -1);
      repeat (150) @(posedge clk);
      #1;
      chk("b2b_frames", framesA - f0a, 2);
      if (gapA.size() == 2) chk("b2b_gap", gapA[1], exp_gap[g]);
      else chk("b2b_gap_count", gapA.size(), 2);
    end
    cfg_ifg = 8'd12;

    // Reset during payload byte 30, then a clean frame.
    send_frame(40, -1, 0, 30);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    run_vec(vecs[5]);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", nchk, nerr);
    $fatal(1);
  end

endmodule
